// File: rtl/ddr_rd_pkg.sv
// Shared constants, output-stage state encoding and
// the almost-full threshold helper for the DDR read unpacker.
package ddr_rd_pkg;

  localparam int DDR_DATA_W = 512;
  localparam int LANE_W     = 128;
  localparam int LANES      = DDR_DATA_W / LANE_W;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_FETCH,
    S_DRAIN
  } ostate_e;

  function automatic int full_thresh(
    input int burst,
    input int margin
  );
    return burst + margin;
  endfunction

endpackage

// File: rtl/ddr_rd_buf_ram.sv
// Simple dual-port beat buffer, one write and one
// registered read port (1-cycle latency, read-first).
module ddr_rd_buf_ram #(
  parameter int DATA_W = 512,
  parameter int DEPTH  = 512,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ddr_rd_unpack.sv
// Buffers 512-bit DDR read beats and serialises each
// into four 128-bit words on a valid/ready stream.
module ddr_rd_unpack #(
  parameter int DATA_W      = 512,
  parameter int LANE_W      = 128,
  parameter int DEPTH       = 512,
  parameter int BURST_NUM   = 128,
  parameter int FULL_MARGIN = 8,
  parameter int AW          = $clog2(DEPTH)
) (
  input  logic              ddr_ui_clk,
  input  logic              ddr_log_rst,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] ddr_rd_data,
  input  logic              ddr_rd_data_en,
  output logic              o_dn_full,
  output logic [LANE_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [AW:0]       o_fill_level,
  output logic              o_overflow,
  output logic [31:0]       o_word_cnt
);
  import ddr_rd_pkg::*;

  localparam int NLANE = DATA_W / LANE_W;
  localparam int LW    = (NLANE > 1) ? $clog2(NLANE) : 1;
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);
  localparam logic [AW:0] THR =
    (AW+1)'(full_thresh(BURST_NUM, FULL_MARGIN));

  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW-1:0]     raddr;
  logic [AW:0]       count;
  logic              q_ok;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] ram_q;
  logic [LW-1:0]     lane;
  ostate_e           state;
  logic              wr;
  logic              hs;
  logic              last;
  logic              load;

  assign wr   = ddr_rd_data_en && (count != CAP) && !i_flush;
  assign hs   = m_valid && m_ready;
  assign last = hs && (lane == LW'(NLANE - 1));
  assign load = q_ok &&
    ((state == S_FETCH) || ((state == S_DRAIN) && last));

  // Read port looks ahead so ram_q always holds mem[rptr];
  // q_ok marks it as a fully written, not yet popped entry.
  assign raddr = load ? rptr + AW'(1) : rptr;

  assign m_data       = hold[lane*LANE_W +: LANE_W];
  assign o_fill_level = count;

  ddr_rd_buf_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (ddr_ui_clk),
    .we    (wr),
    .waddr (wptr),
    .wdata (ddr_rd_data),
    .raddr (raddr),
    .rdata (ram_q)
  );

  always_ff @(posedge ddr_ui_clk or posedge ddr_log_rst) begin
    if (ddr_log_rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      q_ok       <= 1'b0;
      o_dn_full  <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_dn_full <= (CAP - count) < THR;
      if (ddr_rd_data_en && (count == CAP) && !i_flush)
        o_overflow <= 1'b1;
      if (i_flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
        q_ok  <= 1'b0;
      end else begin
        if (wr) wptr <= wptr + AW'(1);
        if (load) rptr <= raddr;
        count <= count + (AW+1)'(wr) - (AW+1)'(load);
        q_ok  <= (count - (AW+1)'(load)) != '0;
      end
    end
  end

  always_ff @(posedge ddr_ui_clk or posedge ddr_log_rst) begin
    if (ddr_log_rst) begin
      state      <= S_EMPTY;
      lane       <= '0;
      hold       <= '0;
      m_valid    <= 1'b0;
      o_word_cnt <= '0;
    end else if (i_flush) begin
      state   <= S_EMPTY;
      lane    <= '0;
      hold    <= '0;
      m_valid <= 1'b0;
    end else begin
      if (hs) o_word_cnt <= o_word_cnt + 32'd1;
      unique case (state)
        S_EMPTY: begin
          if (q_ok) state <= S_FETCH;
        end
        S_FETCH: begin
          if (q_ok) begin
            hold    <= ram_q;
            lane    <= '0;
            m_valid <= 1'b1;
            state   <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (hs) begin
            if (!last) begin
              lane <= lane + LW'(1);
            end else if (q_ok) begin
              hold <= ram_q;
              lane <= '0;
            end else begin
              m_valid <= 1'b0;
              state   <= (count != '0) ? S_FETCH : S_EMPTY;
            end
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_rd_unpack.sv
// Scoreboard bench for ddr_rd_unpack: directed beats,
// monitor pops expected words on every handshake.
module tb_ddr_rd_unpack;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         en = 1'b0;
  logic         m_ready = 1'b0;
  logic [511:0] din = '0;
  logic         dn_full;
  logic         m_valid;
  logic         ovf;
  logic [127:0] m_data;
  logic [9:0]   fill;
  logic [31:0]  wcnt;

  always #5 clk = ~clk;

  ddr_rd_unpack dut (
    .ddr_ui_clk     (clk),
    .ddr_log_rst    (rst),
    .i_flush        (flush),
    .ddr_rd_data    (din),
    .ddr_rd_data_en (en),
    .o_dn_full      (dn_full),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .o_fill_level   (fill),
    .o_overflow     (ovf),
    .o_word_cnt     (wcnt)
  );

  int           n_chk = 0;
  int           n_fail = 0;
  int           exp_words = 0;
  logic [127:0] sb [$];
  logic [127:0] held;
  logic [127:0] expw;
  bit           stall_pend = 0;

  task automatic chk(input string nm,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [511:0] beat(input int k);
    logic [511:0] b;
    for (int j = 0; j < 4; j++)
      b[j*128 +: 128] = {32'(k), 32'(j), ~32'(k),
                         32'hC0DE_0000 | 32'(j)};
    return b;
  endfunction

  task automatic push(input logic [511:0] d);
    for (int j = 0; j < 4; j++) sb.push_back(d[j*128 +: 128]);
    exp_words += 4;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [511:0] d, input bit keep);
    din = d;
    en  = 1'b1;
    if (keep) push(d);
    step();
    en = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int lim);
    int c = 0;
    while ((m_valid || fill != 0) && c < lim) begin
      step();
      c++;
    end
    chk({nm, "_drain_timeout"}, 128'(c < lim), 128'(1));
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stall_pend = 0;
    end else begin
      if (stall_pend && m_valid) chk("stall_hold", m_data, held);
      stall_pend = m_valid && !m_ready;
      held = m_data;
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_word: got %h expected none", m_data);
        end else begin
          expw = sb.pop_front();
          chk("word", m_data, expw);
        end
      end
    end
  end

  initial begin
    logic [511:0] tp;
    int lat, nv, c;
    bit seen, ended, gap;

    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_valid", 128'(m_valid), 128'(0));
    chk("rst_fill", 128'(fill), 128'(0));
    chk("rst_full", 128'(dn_full), 128'(0));
    chk("rst_ovf", 128'(ovf), 128'(0));
    chk("rst_wcnt", 128'(wcnt), 128'(0));
    chk("rst_data", m_data, 128'(0));

    // single beat, latency and lane order
    m_ready = 1'b1;
    tp = {{32{4'h3}}, {32{4'h2}}, {32{4'h1}}, {32{4'h0}}};
    wr(tp, 1);
    lat = 0;
    while (!m_valid && lat < 10) begin
      step();
      lat++;
    end
    chk("latency", 128'(lat), 128'(3));
    chk("first_word", m_data, 128'(0));
    wait_idle("single", 50);
    chk("single_wcnt", 128'(wcnt), 128'(exp_words));

    // 128-beat burst, no bubbles
    nv = 0; seen = 0; ended = 0; gap = 0;
    for (int i = 0; i < 700; i++) begin
      if (i < 128) begin
        din = beat(i);
        en  = 1'b1;
        push(din);
      end else begin
        en = 1'b0;
      end
      step();
      if (m_valid) begin
        nv++;
        seen = 1;
        if (ended) gap = 1;
      end else if (seen) begin
        ended = 1;
      end
    end
    en = 1'b0;
    chk("burst_valid_cycles", 128'(nv), 128'(512));
    chk("burst_gap", 128'(gap), 128'(0));
    chk("burst_fill", 128'(fill), 128'(0));
    chk("burst_wcnt", 128'(wcnt), 128'(exp_words));

    // almost-full threshold; one beat sits in the output stage
    m_ready = 1'b0;
    for (int i = 0; i < 377; i++) wr(beat(1000 + i), 1);
    repeat (2) step();
    chk("thr_fill_376", 128'(fill), 128'(376));
    chk("thr_full_376", 128'(dn_full), 128'(0));
    wr(beat(1377), 1);
    chk("thr_fill_377", 128'(fill), 128'(377));
    chk("thr_full_lag", 128'(dn_full), 128'(0));
    step();
    chk("thr_full_set", 128'(dn_full), 128'(1));
    m_ready = 1'b1;
    c = 0;
    while (dn_full && c < 200) begin
      step();
      c++;
    end
    chk("thr_clear_timeout", 128'(c < 200), 128'(1));
    chk("thr_clear_level", 128'(fill <= 10'd376), 128'(1));
    wait_idle("thr", 3000);
    chk("thr_wcnt", 128'(wcnt), 128'(exp_words));

    // overflow: 1 held + 512 buffered, the next beat is dropped
    m_ready = 1'b0;
    for (int i = 0; i < 513; i++) wr(beat(2000 + i), 1);
    step();
    chk("ovf_fill_full", 128'(fill), 128'(512));
    chk("ovf_not_yet", 128'(ovf), 128'(0));
    wr(beat(9999), 0);
    chk("ovf_set", 128'(ovf), 128'(1));
    chk("ovf_fill_hold", 128'(fill), 128'(512));
    m_ready = 1'b1;
    wait_idle("ovf", 3000);
    chk("ovf_wcnt", 128'(wcnt), 128'(exp_words));

    // random stalls mid-beat
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) wr(beat(3000 + i), 1);
    for (int i = 0; i < 80; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      step();
    end
    m_ready = 1'b1;
    wait_idle("stall", 200);
    chk("stall_wcnt", 128'(wcnt), 128'(exp_words));

    // flush with lane=2 and 10 beats buffered
    m_ready = 1'b0;
    for (int i = 0; i < 11; i++) wr(beat(4000 + i), 1);
    repeat (3) step();
    chk("flush_pre_fill", 128'(fill), 128'(10));
    m_ready = 1'b1;
    repeat (2) step();
    m_ready = 1'b0;
    chk("flush_lane2", m_data, sb[0]);
    flush = 1'b1;
    din = beat(4999);
    en = 1'b1;
    exp_words -= sb.size();
    sb.delete();
    step();
    flush = 1'b0;
    en = 1'b0;
    chk("flush_valid", 128'(m_valid), 128'(0));
    chk("flush_fill", 128'(fill), 128'(0));
    chk("flush_ovf_kept", 128'(ovf), 128'(1));
    chk("flush_wcnt_kept", 128'(wcnt), 128'(exp_words));
    step();
    chk("flush_still_empty", 128'(m_valid || fill != 0), 128'(0));
    m_ready = 1'b1;
    wr(beat(5000), 1);
    wait_idle("post_flush", 50);
    chk("post_flush_wcnt", 128'(wcnt), 128'(exp_words));

    // asynchronous reset in the middle of a cycle
    m_ready = 1'b0;
    wr(beat(6000), 1);
    wr(beat(6001), 1);
    repeat (4) step();
    chk("arst_pre_valid", 128'(m_valid), 128'(1));
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 128'(m_valid), 128'(0));
    chk("arst_fill", 128'(fill), 128'(0));
    chk("arst_ovf", 128'(ovf), 128'(0));
    chk("arst_wcnt", 128'(wcnt), 128'(0));
    chk("arst_full", 128'(dn_full), 128'(0));
    chk("arst_data", m_data, 128'(0));
    sb.delete();
    exp_words = 0;
    step();
    rst = 1'b0;
    step();
    m_ready = 1'b1;
    wr(beat(7000), 1);
    wait_idle("post_rst", 50);
    chk("post_rst_wcnt", 128'(wcnt), 128'(4));

    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
